// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned MaxWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/half_add.sv
// Single-bit half adder.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full-adder bit cell built from two half adders.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_add u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_add u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell sequenced over WIDTH cycles,
// with valid/ready request and result handshakes and a held result register.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CntMsb  = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;

    serial_fa_cell u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sha_d   = a;
                    shb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                acc_d   = (acc_q >> 1) | {fa_s, (WIDTH - 1)'(0)};
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CntMsb) begin
                    c_msb_d = fa_co;
                end
                if (cnt_q == CntLast) begin
                    sum_d   = acc_d;
                    cout_d  = fa_co;
                    ovf_d   = c_msb_q ^ fa_co;
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sha_q   <= '0;
            shb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StHold);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [7:0] a, b, sum;

    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, ovf2, busy2;
    logic [1:0] a2, b2, sum2;

    int         n_vec;
    int         n_err;
    int         cyc;
    int         last_acc;
    bit         have_last;
    logic [9:0] exp_res;  // {cout, ovf, sum} currently held by the W=8 DUT

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .cout      (cout2),
        .ovf       (ovf2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {cout, ovf, sum} from plain integer addition.
    function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned t;
        logic [8:0]  f;
        logic        v;
        t = 32'(x) + 32'(y) + 32'(c);
        f = t[8:0];
        v = (x[7] == y[7]) && (f[7] != x[7]);
        return {f[8], v, f[7:0]};
    endfunction

    function automatic logic [3:0] ref2(input logic [1:0] x, input logic [1:0] y, input logic c);
        int unsigned t;
        logic [2:0]  f;
        logic        v;
        t = 32'(x) + 32'(y) + 32'(c);
        f = t[2:0];
        v = (x[1] == y[1]) && (f[1] != x[1]);
        return {f[2], v, f[1:0]};
    endfunction

    // One W=8 operation; called and returns at a negedge. churn keeps in_valid high and
    // scrambles operands during RUN so the next call issues back-to-back.
    task automatic op8(input logic [7:0] na, input logic [7:0] nb, input logic nc,
                       input int stall, input bit churn);
        int         guard;
        logic [9:0] r;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_ready", 32'(in_ready), 32'd1);
        a        = na;
        b        = nb;
        cin      = nc;
        in_valid = 1'b1;
        r        = ref8(na, nb, nc);
        @(posedge clk);
        @(negedge clk);
        if (churn) begin
            if (have_last) check("issue_gap", 32'(cyc - last_acc), 32'd10);
            last_acc  = cyc;
            have_last = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            check("run_flags", 32'({out_valid, busy, in_ready}), 32'b010);
            check("run_out_held", 32'({cout, ovf, sum}), 32'(exp_res));
            out_ready = 1'($urandom);
            if (churn) {a, b, cin} = 17'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b0;
        exp_res   = r;
        check("result", 32'({out_valid, cout, ovf, sum}), 32'({1'b1, r}));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall", 32'({out_valid, in_ready, busy, cout, ovf, sum}), 32'({3'b100, r}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_flags", 32'({out_valid, in_ready, busy}), 32'b010);
        check("release_held", 32'({cout, ovf, sum}), 32'(r));
    endtask

    task automatic op2(input logic [1:0] na, input logic [1:0] nb, input logic nc);
        int         guard;
        logic [3:0] r;
        guard = 0;
        while (!in_ready2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("w2_idle_ready", 32'(in_ready2), 32'd1);
        a2        = na;
        b2        = nb;
        cin2      = nc;
        in_valid2 = 1'b1;
        r         = ref2(na, nb, nc);
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        check("w2_run", 32'({out_valid2, busy2}), 32'b01);
        @(negedge clk);
        check("w2_run2", 32'({out_valid2, busy2}), 32'b01);
        @(negedge clk);
        check("w2_result", 32'({out_valid2, cout2, ovf2, sum2}), 32'({1'b1, r}));
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("w2_release", 32'({out_valid2, in_ready2}), 32'b01);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        last_acc   = 0;
        have_last  = 1'b0;
        exp_res    = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        a2         = '0;
        b2         = '0;
        cin2       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_outs", 32'({out_valid, busy, cout, ovf, sum}), 32'd0);
        check("rst_outs2", 32'({out_valid2, busy2, cout2, ovf2, sum2}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'({in_ready, in_ready2}), 32'b11);

        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        check("tp1_const", 32'({cout, ovf, sum}), 32'({1'b1, 1'b0, 8'h00}));
        op8(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        check("tp2a_const", 32'({cout, ovf, sum}), 32'({1'b0, 1'b1, 8'h80}));
        op8(8'h80, 8'h80, 1'b1, 0, 1'b0);
        check("tp2b_const", 32'({cout, ovf, sum}), 32'({1'b1, 1'b1, 8'h01}));

        op8(8'h3C, 8'hA5, 1'b1, 5, 1'b0);

        have_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1);
        end
        in_valid = 1'b0;

        // Abort mid-RUN: reset lands on the 4th RUN cycle.
        @(negedge clk);
        a        = 8'h55;
        b        = 8'hAA;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outs", 32'({out_valid, busy, cout, ovf, sum}), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_res = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("post_abort", 32'({out_valid, in_ready, busy, cout, ovf, sum}),
                  32'({3'b010, 10'd0}));
        end

        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        op2(2'd3, 2'd3, 1'b1);
        check("w2_const", 32'({cout2, ovf2, sum2}), 32'({1'b1, 1'b0, 2'd3}));
        for (int i = 0; i < 40; i++) begin
            op2(2'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
